// File: rtl/svdb_reg_rtl_pkg.sv
// svdb_reg_rtl_pkg: shared access codes, response FSM states and decode helpers for the register responder
package svdb_reg_rtl_pkg;
  typedef enum logic [1:0] {ACC_RW, ACC_RO, ACC_WO} svdb_acc_e;
  typedef enum logic {ST_IDLE, ST_RESP} svdb_rsp_st_e;
  localparam int BYTE_SHIFT = 2;
  // code 2'b11 is not named and falls through as read-only
  function automatic logic acc_rd_ok(input logic [1:0] a);
    return a != ACC_WO;
  endfunction
  function automatic logic acc_wr_ok(input logic [1:0] a);
    return a == ACC_RW || a == ACC_WO;
  endfunction
endpackage

// File: rtl/svdb_reg_cell.sv
// svdb_reg_cell: one register with access policy, hw update and byte strobes (SVDB_REG_WSTRB_EN)
module svdb_reg_cell
  import svdb_reg_rtl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter logic [1:0] ACCESS = 2'b00,
  parameter logic [DATA_W-1:0] RESET = '0,
  parameter bit VOLATILE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_bus_we,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W/8-1:0] i_wstrb,
  input  logic              i_hw_we,
  input  logic [DATA_W-1:0] i_hw_data,
  output logic [DATA_W-1:0] o_q
);
  logic [DATA_W-1:0] r_q, w_smask, w_bmask, w_hmask;
`ifdef SVDB_REG_WSTRB_EN
  for (genvar b = 0; b < DATA_W/8; b++) begin : g_strb
    assign w_smask[8*b +: 8] = {8{i_wstrb[b]}};
  end
`else
  logic w_unused_wstrb;
  assign w_unused_wstrb = ^i_wstrb;
  assign w_smask = '1;
`endif
  assign w_bmask = (i_bus_we && acc_wr_ok(ACCESS)) ? w_smask : '0;
  assign w_hmask = (VOLATILE && i_hw_we) ? ~w_bmask : '0;
  // bytes written by the bus beat a same-edge hw update; remaining bytes take hw data or hold
  always_ff @(posedge clk)
    if (rst) r_q <= RESET;
    else r_q <= (i_wdata & w_bmask) | (i_hw_data & w_hmask) | (r_q & ~(w_bmask | w_hmask));
  assign o_q = r_q;
endmodule

// File: rtl/svdb_reg_responder.sv
// svdb_reg_responder: valid/ready register-bank target with RW/RO/WO policy; byte strobes with SVDB_REG_WSTRB_EN
module svdb_reg_responder
  import svdb_reg_rtl_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter logic [NUM_REGS*2-1:0] REG_ACCESS = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] REG_RESET = '0,
  parameter logic [NUM_REGS-1:0] REG_VOLATILE = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_wdata,
  input  logic [DATA_W/8-1:0]        req_wstrb,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  input  logic [NUM_REGS-1:0]        hw_wr_en,
  input  logic [NUM_REGS*DATA_W-1:0] hw_wr_data,
  output logic [NUM_REGS*DATA_W-1:0] reg_q
);
  localparam logic [ADDR_W-1:0] LIM = ADDR_W'(NUM_REGS);
  svdb_rsp_st_e r_state;
  logic r_rsp_valid, r_err;
  logic [DATA_W-1:0] r_rdata;
  logic [ADDR_W-1:0] w_idx;
  logic w_hit, w_accept, w_err;
  logic [1:0] w_acc;
  logic [DATA_W-1:0] w_rval, w_rdata;
  logic [NUM_REGS-1:0] w_we;
  logic [DATA_W-1:0] w_q [NUM_REGS];
  assign w_idx = req_addr >> BYTE_SHIFT;
  assign w_hit = req_addr[BYTE_SHIFT-1:0] == '0 && w_idx < LIM;
  assign w_accept = req_valid && r_state == ST_IDLE;
  assign w_err = !w_hit || (req_write ? !acc_wr_ok(w_acc) : !acc_rd_ok(w_acc));
  assign w_rdata = (req_write || w_err) ? '0 : w_rval;
  // select the addressed register's policy, value and write strobe
  always_comb begin
    w_acc = ACC_RO;
    w_rval = '0;
    w_we = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (w_hit && w_idx == ADDR_W'(i)) begin
        w_acc = REG_ACCESS[2*i +: 2];
        w_rval = w_q[i];
        w_we[i] = w_accept && req_write;
      end
  end
  // response FSM: capture the result at accept, hold it until consumed
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= ST_IDLE;
      r_rsp_valid <= 1'b0;
      r_rdata <= '0;
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_state <= ST_RESP;
      r_rsp_valid <= 1'b1;
      r_rdata <= w_rdata;
      r_err <= w_err;
    end else if (r_state == ST_RESP && rsp_ready) begin
      r_state <= ST_IDLE;
      r_rsp_valid <= 1'b0;
    end
  assign req_ready = r_state == ST_IDLE;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_err = r_err;
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    svdb_reg_cell #(
      .DATA_W(DATA_W),
      .ACCESS(REG_ACCESS[2*i +: 2]),
      .RESET(REG_RESET[DATA_W*i +: DATA_W]),
      .VOLATILE(REG_VOLATILE[i])
    ) u_cell (
      .clk(clk),
      .rst(rst),
      .i_bus_we(w_we[i]),
      .i_wdata(req_wdata),
      .i_wstrb(req_wstrb),
      .i_hw_we(hw_wr_en[i]),
      .i_hw_data(hw_wr_data[DATA_W*i +: DATA_W]),
      .o_q(w_q[i])
    );
    assign reg_q[DATA_W*i +: DATA_W] = w_q[i];
  end
endmodule

// File: tb/tb_svdb_reg_responder.sv
// tb_svdb_reg_responder: directed table, corner sequences and random traffic against a reference model
module tb_svdb_reg_responder;
  localparam logic [15:0] ACC = {2'b10, 2'b01, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00};
  localparam logic [255:0] RSTV = {32'h7777_0007, 32'h6666_0006, 32'h5555_0005, 32'h4444_0004,
                                   32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0000};
  localparam logic [7:0] VOL = 8'b0110_0110;
`ifdef SVDB_REG_WSTRB_EN
  localparam bit STRB = 1'b1;
`else
  localparam bit STRB = 1'b0;
`endif
  int acc_t [8] = '{0, 0, 1, 2, 3, 0, 1, 2};
  logic [31:0] rst_t [8] = '{32'h0, 32'h1111_0001, 32'h2222_0002, 32'h3333_0003,
                             32'h4444_0004, 32'h5555_0005, 32'h6666_0006, 32'h7777_0007};
  bit vol_t [8] = '{0, 1, 1, 0, 0, 1, 1, 0};
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, req_write = 0;
  logic [7:0] req_addr = 0;
  logic [31:0] req_wdata = 0;
  logic [3:0] req_wstrb = 0;
  logic rsp_valid, rsp_ready = 0, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0] hw_wr_en = 0;
  logic [255:0] hw_wr_data = 0, reg_q;
  logic [31:0] m_reg [8];
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  svdb_reg_responder #(.NUM_REGS(8), .ADDR_W(8), .DATA_W(32), .REG_ACCESS(ACC),
                       .REG_RESET(RSTV), .REG_VOLATILE(VOL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .hw_wr_en(hw_wr_en),
    .hw_wr_data(hw_wr_data), .reg_q(reg_q));
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [255:0] mq();
    logic [255:0] q;
    for (int i = 0; i < 8; i++) q[32*i +: 32] = m_reg[i];
    return q;
  endfunction
  // spec-level model: decode, policy, then per-byte new value with bus write beating hw update
  task automatic model(input bit w, input logic [7:0] a, input logic [31:0] wd, input logic [3:0] st,
                       input logic [7:0] hen, input logic [255:0] hd,
                       output logic [31:0] erd, output bit eerr);
    int idx;
    bit ok, rd_ok, wr_ok, bus;
    idx = int'(a) / 4;
    ok = (a % 4 == 0) && idx < 8;
    rd_ok = ok && acc_t[idx] != 2;
    wr_ok = ok && (acc_t[idx] == 0 || acc_t[idx] == 2);
    eerr = w ? !wr_ok : !rd_ok;
    erd = (!w && !eerr) ? m_reg[idx] : 32'h0;
    for (int i = 0; i < 8; i++) begin
      bus = w && wr_ok && idx == i;
      for (int b = 0; b < 4; b++)
        if (bus && (!STRB || st[b])) m_reg[i][8*b +: 8] = wd[8*b +: 8];
        else if (hen[i] && vol_t[i]) m_reg[i][8*b +: 8] = hd[32*i + 8*b +: 8];
    end
  endtask
  task automatic txn(input bit w, input logic [7:0] a, input logic [31:0] wd, input logic [3:0] st,
                     input logic [7:0] hen, input logic [255:0] hd, input int dly, input string nm,
                     output logic [31:0] ord, output logic oerr);
    logic [31:0] erd;
    bit eerr;
    @(negedge clk);
    chk({nm, ":req_ready"}, 256'(req_ready), 256'(1'b1));
    req_valid = 1; req_write = w; req_addr = a; req_wdata = wd; req_wstrb = st;
    hw_wr_en = hen; hw_wr_data = hd; rsp_ready = 0;
    model(w, a, wd, st, hen, hd, erd, eerr);
    @(negedge clk);
    req_valid = 0; hw_wr_en = 0;
    ord = rsp_rdata; oerr = rsp_err;
    chk({nm, ":rsp_valid"}, 256'(rsp_valid), 256'(1'b1));
    chk({nm, ":rdata"}, 256'(rsp_rdata), 256'(erd));
    chk({nm, ":err"}, 256'(rsp_err), 256'(eerr));
    chk({nm, ":reg_q"}, reg_q, mq());
    repeat (dly) @(negedge clk);
    rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0;
  endtask
  typedef struct {
    bit w;
    logic [7:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    bit err;
    string nm;
  } vec_t;
  vec_t vt [$];
  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end
  initial begin
    logic [31:0] ord;
    logic oerr;
    logic [7:0] a, hen;
    logic [255:0] hd;
    for (int i = 0; i < 8; i++) m_reg[i] = rst_t[i];
    for (int i = 0; i < 8; i++)
      vt.push_back('{1'b0, 8'(4*i), 32'h0, (acc_t[i] == 2) ? 32'h0 : rst_t[i], acc_t[i] == 2, $sformatf("rst_rd%0d", i)});
    vt.push_back('{1'b1, 8'h04, 32'hDEAD_BEEF, 32'h0, 1'b0, "wr_rw1"});
    vt.push_back('{1'b0, 8'h04, 32'h0, 32'hDEAD_BEEF, 1'b0, "rd_rw1"});
    vt.push_back('{1'b1, 8'h08, 32'h0000_1234, 32'h0, 1'b1, "wr_ro2"});
    vt.push_back('{1'b0, 8'h08, 32'h0, 32'h2222_0002, 1'b0, "rd_ro2"});
    vt.push_back('{1'b0, 8'h0C, 32'h0, 32'h0, 1'b1, "rd_wo3"});
    vt.push_back('{1'b1, 8'h0C, 32'hCAFE_0003, 32'h0, 1'b0, "wr_wo3"});
    vt.push_back('{1'b0, 8'h0C, 32'h0, 32'h0, 1'b1, "rd_wo3b"});
    vt.push_back('{1'b0, 8'h10, 32'h0, 32'h4444_0004, 1'b0, "rd_acc3"});
    vt.push_back('{1'b1, 8'h10, 32'hFFFF_FFFF, 32'h0, 1'b1, "wr_acc3"});
    vt.push_back('{1'b0, 8'h06, 32'h0, 32'h0, 1'b1, "rd_mis"});
    vt.push_back('{1'b1, 8'h06, 32'hFFFF_FFFF, 32'h0, 1'b1, "wr_mis"});
    vt.push_back('{1'b0, 8'h20, 32'h0, 32'h0, 1'b1, "rd_oor"});
    vt.push_back('{1'b1, 8'h20, 32'hFFFF_FFFF, 32'h0, 1'b1, "wr_oor"});
    vt.push_back('{1'b1, 8'hFC, 32'hFFFF_FFFF, 32'h0, 1'b1, "wr_top"});
    vt.push_back('{1'b0, 8'h04, 32'h0, 32'hDEAD_BEEF, 1'b0, "rd_rw1b"});
    repeat (2) @(negedge clk);
    chk("rst:req_ready", 256'(req_ready), 256'(1'b1));
    chk("rst:rsp_valid", 256'(rsp_valid), 256'(1'b0));
    chk("rst:rdata", 256'(rsp_rdata), 256'(32'h0));
    chk("rst:err", 256'(rsp_err), 256'(1'b0));
    chk("rst:reg_q", reg_q, RSTV);
    rst = 0;
    foreach (vt[k]) begin
      txn(vt[k].w, vt[k].a, vt[k].wd, 4'hF, 8'h0, 256'h0, 0, vt[k].nm, ord, oerr);
      chk({vt[k].nm, ":tbl_rdata"}, 256'(ord), 256'(vt[k].rd));
      chk({vt[k].nm, ":tbl_err"}, 256'(oerr), 256'(vt[k].err));
    end
    // response held with rsp_ready low; changed request lines must be ignored
    @(negedge clk);
    req_valid = 1; req_write = 0; req_addr = 8'h04; rsp_ready = 0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("hold:rsp_valid", 256'(rsp_valid), 256'(1'b1));
      chk("hold:req_ready", 256'(req_ready), 256'(1'b0));
      chk("hold:rdata", 256'(rsp_rdata), 256'(32'hDEAD_BEEF));
      chk("hold:err", 256'(rsp_err), 256'(1'b0));
      req_write = 1; req_wdata = 32'h0; req_wstrb = 4'hF;
      @(negedge clk);
    end
    req_valid = 0; rsp_ready = 1;
    @(negedge clk);
    chk("hold:released", 256'(rsp_valid), 256'(1'b0));
    chk("hold:idle", 256'(req_ready), 256'(1'b1));
    chk("hold:reg_q", reg_q, mq());
    rsp_ready = 0;
    // same-edge hw update vs bus write
    hd = {8{32'h5555_5555}};
    txn(1, 8'h04, 32'h0BAD_F00D, 4'hF, 8'h03, hd, 0, "coll_rw", ord, oerr);
    chk("coll_rw:bus_wins", 256'(reg_q[63:32]), 256'(32'h0BAD_F00D));
    chk("coll_rw:nonvol", 256'(reg_q[31:0]), 256'(32'h0));
    hd = {8{32'hA5A5_A5A5}};
    txn(1, 8'h08, 32'h1234_5678, 4'hF, 8'h04, hd, 1, "coll_ro", ord, oerr);
    chk("coll_ro:hw_wins", 256'(reg_q[95:64]), 256'(32'hA5A5_A5A5));
    // byte strobes
    txn(1, 8'h04, 32'hDEAD_BEEF, 4'hF, 8'h0, 256'h0, 0, "strb_init", ord, oerr);
    txn(1, 8'h04, 32'h1122_3344, 4'b0101, 8'h0, 256'h0, 0, "strb_wr", ord, oerr);
    txn(1, 8'h04, 32'h9999_9999, 4'b0000, 8'h0, 256'h0, 0, "strb_zero", ord, oerr);
    txn(0, 8'h04, 32'h0, 4'h0, 8'h0, 256'h0, 0, "strb_rd", ord, oerr);
`ifdef SVDB_REG_WSTRB_EN
    chk("strb:merged", 256'(ord), 256'(32'hDE22_BE44));
`endif
    // reset while a response is pending, with a new request presented
    @(negedge clk);
    req_valid = 1; req_write = 0; req_addr = 8'h04; rsp_ready = 0;
    @(negedge clk);
    chk("rst_resp:valid_before", 256'(rsp_valid), 256'(1'b1));
    rst = 1;
    @(negedge clk);
    chk("rst_resp:dropped", 256'(rsp_valid), 256'(1'b0));
    chk("rst_resp:idle", 256'(req_ready), 256'(1'b1));
    chk("rst_resp:reg_q", reg_q, RSTV);
    rst = 0; req_valid = 0;
    for (int i = 0; i < 8; i++) m_reg[i] = rst_t[i];
    @(negedge clk);
    chk("rst_resp:no_accept", 256'(rsp_valid), 256'(1'b0));
    // random traffic
    for (int k = 0; k < 300; k++) begin
      a = 8'($urandom_range(0, 9)) << 2;
      if ($urandom_range(0, 7) == 0) a = a | 8'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) a = 8'($urandom);
      hen = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h0;
      for (int i = 0; i < 8; i++) hd[32*i +: 32] = $urandom;
      txn(1'($urandom), a, $urandom, 4'($urandom), hen, hd, $urandom_range(0, 2),
          $sformatf("rnd%0d", k), ord, oerr);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
